// File: rtl/motion_avm_copy_master.sv
// Avalon-MM word-copy master: reads src..src+len-1 and writes them to dst.., one word at a time, ascending.
// Optional running write checksum is enabled by defining MOTION_AVM_COPY_CHECKSUM_EN.
module motion_avm_copy_master #(
   parameter int ADDR_W       = 13,
   parameter int LEN_W        = 14,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic [31:0]       checksum,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_read,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  remaining;
   logic [2:0]        lat_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         src_ptr        <= '0;
         dst_ptr        <= '0;
         remaining      <= '0;
         lat_cnt        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         avm_address    <= '0;
         avm_chipselect <= 1'b0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_byteenable <= 4'h0;
         avm_writedata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (length != '0) begin
                     src_ptr        <= src_addr;
                     dst_ptr        <= dst_addr;
                     remaining      <= length;
                     busy           <= 1'b1;
                     avm_read       <= 1'b1;
                     avm_chipselect <= 1'b1;
                     avm_address    <= src_addr;
                     state          <= RD_REQ;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RD_REQ: begin
               if (!avm_waitrequest) begin
                  avm_read       <= 1'b0;
                  avm_chipselect <= 1'b0;
                  avm_address    <= '0;
                  lat_cnt        <= 3'(READ_LATENCY);
                  state          <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               // Slave data is valid on the edge where the countdown reaches 1.
               if (lat_cnt == 3'd1) begin
                  avm_writedata  <= avm_readdata;
                  avm_write      <= 1'b1;
                  avm_chipselect <= 1'b1;
                  avm_byteenable <= 4'hF;
                  avm_address    <= dst_ptr;
                  state          <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (!avm_waitrequest) begin
                  avm_write      <= 1'b0;
                  avm_byteenable <= 4'h0;
                  src_ptr        <= src_ptr + ADDR_W'(1);
                  dst_ptr        <= dst_ptr + ADDR_W'(1);
                  remaining      <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     avm_chipselect <= 1'b0;
                     avm_address    <= '0;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                     state          <= DONE;
                  end else begin
                     avm_read    <= 1'b1;
                     avm_address <= src_ptr + ADDR_W'(1);
                     state       <= RD_REQ;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MOTION_AVM_COPY_CHECKSUM_EN
   logic [31:0] csum;

   always_ff @(posedge clk) begin
      if (reset)
         csum <= '0;
      else if (state == IDLE && start)
         csum <= '0;
      else if (state == WR_REQ && !avm_waitrequest)
         csum <= csum + avm_writedata;
   end

   assign checksum = csum;
`else
   assign checksum = 32'h0;
`endif

endmodule
